// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem request/response
// handshake and presents fetched instructions to decode over valid/ready.
module fetch_ctrl #(
   parameter int unsigned       PC_W     = 8,
   parameter int unsigned       INSTR_W  = 32,
   parameter logic [PC_W-1:0]   RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   output logic               if_valid,
   input  logic               if_ready,
   output logic [INSTR_W-1:0] if_instr,
   output logic [PC_W-1:0]    if_pc,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic [PC_W-1:0]    pc_out
);

   localparam int unsigned ST_W = 3;

   localparam logic [ST_W-1:0] IDLE     = 3'd0;
   localparam logic [ST_W-1:0] REQ      = 3'd1;
   localparam logic [ST_W-1:0] WAIT_RSP = 3'd2;
   localparam logic [ST_W-1:0] DRAIN    = 3'd3;
   localparam logic [ST_W-1:0] HOLD     = 3'd4;

   localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);
   localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);

   logic [ST_W-1:0]    state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [PC_W-1:0]    if_pc_q, if_pc_d;
   logic               req_valid_q;
   logic               if_valid_q;
   logic [PC_W-1:0]    redir_pc_c;

   // Redirect targets are forced word-aligned so the PC never leaves alignment.
   assign redir_pc_c = redirect_pc & ALIGN_MASK;

   // Next-state logic; redirect outranks every handshake.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      if_pc_d = if_pc_q;
      unique case (state_q)
         IDLE: begin
            if (redirect_valid) pc_d = redir_pc_c;
            state_d = REQ;
         end
         REQ: begin
            if (redirect_valid) begin
               pc_d = redir_pc_c;
               if (imem_req_ready) state_d = DRAIN;
            end else if (imem_req_ready) begin
               state_d = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            if (redirect_valid) begin
               pc_d    = redir_pc_c;
               state_d = imem_rsp_valid ? REQ : DRAIN;
            end else if (imem_rsp_valid) begin
               instr_d = imem_rsp_data;
               if_pc_d = pc_q;
               pc_d    = pc_q + PC_STEP;
               state_d = HOLD;
            end
         end
         DRAIN: begin
            if (redirect_valid) pc_d = redir_pc_c;
            if (imem_rsp_valid) state_d = REQ;
         end
         HOLD: begin
            if (redirect_valid) begin
               pc_d    = redir_pc_c;
               state_d = REQ;
            end else if (if_ready) begin
               state_d = REQ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; the valid strobes are registered copies
   // of the upcoming state so no input reaches an output combinationally.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC & ALIGN_MASK;
         instr_q     <= '0;
         if_pc_q     <= '0;
         req_valid_q <= 1'b0;
         if_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         if_pc_q     <= if_pc_d;
         req_valid_q <= (state_d == REQ);
         if_valid_q  <= (state_d == HOLD);
      end
   end

   assign imem_req_valid = req_valid_q;
   assign imem_addr      = pc_q;
   assign pc_out         = pc_q;
   assign if_valid       = if_valid_q;
   assign if_instr       = instr_q;
   assign if_pc          = if_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: latency-programmable memory model plus a
// scoreboard of expected fetch PCs popped on every decode handshake.
module tb_fetch_ctrl;

   localparam int unsigned PC_W    = 8;
   localparam int unsigned INSTR_W = 32;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               imem_req_valid;
   logic               imem_req_ready = 1'b1;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_rsp_valid = 1'b0;
   logic [INSTR_W-1:0] imem_rsp_data = 32'hDEAD_BEEF;
   logic               if_valid;
   logic               if_ready = 1'b0;
   logic [INSTR_W-1:0] if_instr;
   logic [PC_W-1:0]    if_pc;
   logic               redirect_valid = 1'b0;
   logic [PC_W-1:0]    redirect_pc = '0;
   logic [PC_W-1:0]    pc_out;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int rsp_lat  = 1;
   int pend_cnt = 0;
   logic [PC_W-1:0] pend_addr = '0;
   logic [PC_W-1:0] mon_pc;
   logic [PC_W-1:0] sb[$];
   int hs_cyc[$];

   fetch_ctrl #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(8'h00)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .pc_out         (pc_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [INSTR_W-1:0] mem_word(input logic [PC_W-1:0] a);
      return {8'hC3, a, ~a, 8'h5A};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_empty(input string tag, input int max_cyc);
      int n = 0;
      while (sb.size() != 0 && n < max_cyc) begin
         step();
         n++;
      end
      check_eq({tag, "_drained"}, 32'(sb.size()), 32'd0);
   endtask

   task automatic wait_valid(input string tag, input int max_cyc);
      int n = 0;
      while (!if_valid && n < max_cyc) begin
         step();
         n++;
      end
      check_eq({tag, "_if_valid"}, 32'(if_valid), 32'd1);
   endtask

   // Memory: responds rsp_lat cycles after an accepted request, one pulse.
   always @(negedge clk) begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
      if (pend_cnt > 0) begin
         pend_cnt = pend_cnt - 1;
         if (pend_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr);
         end
      end
      if (imem_req_valid && imem_req_ready) begin
         pend_addr = imem_addr;
         pend_cnt  = rsp_lat;
      end
   end

   // Decode-side monitor: a consumed instruction must match the scoreboard head.
   always @(negedge clk) begin
      if (!rst && if_valid && if_ready && !redirect_valid) begin
         check_eq("sb_nonempty", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            mon_pc = sb.pop_front();
            check_eq("if_pc", 32'(if_pc), 32'(mon_pc));
            check_eq("if_instr", if_instr, mem_word(mon_pc));
            hs_cyc.push_back(cyc);
         end
      end
   end

   initial begin
      // Reset state
      step();
      step();
      check_eq("rst_pc_out", 32'(pc_out), 32'h00);
      check_eq("rst_imem_addr", 32'(imem_addr), 32'h00);
      check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check_eq("rst_if_valid", 32'(if_valid), 32'd0);
      check_eq("rst_if_instr", if_instr, 32'h0);
      check_eq("rst_if_pc", 32'(if_pc), 32'h00);
      rst = 1'b0;
      check_eq("idle_req_valid", 32'(imem_req_valid), 32'd0);
      step();
      check_eq("first_req_valid", 32'(imem_req_valid), 32'd1);
      check_eq("first_req_addr", 32'(imem_addr), 32'h00);

      // Zero-wait streaming: 0x00, 0x04, 0x08 at one per 3 cycles
      sb.push_back(8'h00);
      sb.push_back(8'h04);
      sb.push_back(8'h08);
      if_ready = 1'b1;
      wait_empty("stream", 40);
      if_ready = 1'b0;
      check_eq("stream_hs_count", 32'(hs_cyc.size()), 32'd3);
      if (hs_cyc.size() >= 3) begin
         check_eq("stream_gap0", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
         check_eq("stream_gap1", 32'(hs_cyc[2] - hs_cyc[1]), 32'd3);
      end

      // Backpressure in HOLD
      wait_valid("bp", 20);
      for (int i = 0; i < 5; i++) begin
         check_eq("bp_if_valid", 32'(if_valid), 32'd1);
         check_eq("bp_if_pc", 32'(if_pc), 32'h0C);
         check_eq("bp_if_instr", if_instr, mem_word(8'h0C));
         check_eq("bp_no_req", 32'(imem_req_valid), 32'd0);
         step();
      end
      sb.push_back(8'h0C);
      if_ready = 1'b1;
      wait_empty("bp", 10);
      if_ready = 1'b0;
      rsp_lat  = 3;
      check_eq("bp_next_req", 32'(imem_req_valid), 32'd1);
      check_eq("bp_next_addr", 32'(imem_addr), 32'h10);

      // Redirect in WAIT_RSP; stale response lands two cycles later
      step();
      check_eq("wr_wait_no_req", 32'(imem_req_valid), 32'd0);
      redirect_valid = 1'b1;
      redirect_pc    = 8'h40;
      step();
      redirect_valid = 1'b0;
      check_eq("wr_pc_out", 32'(pc_out), 32'h40);
      check_eq("wr_drain_no_req", 32'(imem_req_valid), 32'd0);
      step();
      check_eq("wr_stale_no_req", 32'(imem_req_valid), 32'd0);
      step();
      check_eq("wr_req_valid", 32'(imem_req_valid), 32'd1);
      check_eq("wr_req_addr", 32'(imem_addr), 32'h40);
      rsp_lat = 1;
      sb.push_back(8'h40);
      if_ready = 1'b1;
      wait_empty("wr", 20);
      if_ready = 1'b0;

      // Redirect coincident with if_ready in HOLD, unaligned target
      wait_valid("hr", 20);
      check_eq("hr_if_pc", 32'(if_pc), 32'h44);
      if_ready       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 8'h23;
      step();
      if_ready       = 1'b0;
      redirect_valid = 1'b0;
      check_eq("hr_if_valid", 32'(if_valid), 32'd0);
      check_eq("hr_req_valid", 32'(imem_req_valid), 32'd1);
      check_eq("hr_req_addr", 32'(imem_addr), 32'h20);
      check_eq("hr_hs_count", 32'(hs_cyc.size()), 32'd5);
      sb.push_back(8'h20);
      if_ready = 1'b1;
      wait_empty("hr", 20);
      if_ready = 1'b0;

      // PC wrap from 0xFC to 0x00
      wait_valid("wrap", 20);
      redirect_valid = 1'b1;
      redirect_pc    = 8'hFC;
      step();
      redirect_valid = 1'b0;
      check_eq("wrap_pc_out", 32'(pc_out), 32'hFC);
      check_eq("wrap_if_valid", 32'(if_valid), 32'd0);
      sb.push_back(8'hFC);
      sb.push_back(8'h00);
      if_ready = 1'b1;
      wait_empty("wrap", 30);
      if_ready = 1'b0;

      // Reset while in WAIT_RSP; stale response arrives in the IDLE cycle
      rsp_lat = 2;
      check_eq("rw_req_addr", 32'(imem_addr), 32'h04);
      step();
      check_eq("rw_wait_no_req", 32'(imem_req_valid), 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("rw_pc_out", 32'(pc_out), 32'h00);
      check_eq("rw_req_valid", 32'(imem_req_valid), 32'd0);
      check_eq("rw_if_valid", 32'(if_valid), 32'd0);
      check_eq("rw_if_instr", if_instr, 32'h0);
      check_eq("rw_if_pc", 32'(if_pc), 32'h00);
      step();
      check_eq("rw_first_req", 32'(imem_req_valid), 32'd1);
      check_eq("rw_first_addr", 32'(imem_addr), 32'h00);
      check_eq("rw_pc_stable", 32'(pc_out), 32'h00);
      sb.push_back(8'h00);
      if_ready = 1'b1;
      wait_empty("rw", 20);
      if_ready = 1'b0;

      repeat (6) step();
      check_eq("final_sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer that owns the program counter and drives the instruction-memory request/response handshake. It advances the PC in 4-byte steps, accepts branch/jump redirects from execute, and delivers fetched instructions to decode over a valid/ready handshake. It sits between the PC register path and the IF/ID boundary, and supersedes free-running PC increment.

## Interface
- PC_W, 8, PC and address width (byte address)
- INSTR_W, 32, instruction width
- RESET_PC, 0, PC value loaded on reset; low 2 bits must be 0
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request this cycle
- imem_addr  output  PC_W  fetch address (equals pc_out)
- imem_rsp_valid  input  1  response data valid (1-cycle pulse)
- imem_rsp_data  input  INSTR_W  fetched instruction
- if_valid  output  1  instruction available to decode
- if_ready  input  1  decode accepts instruction
- if_instr  output  INSTR_W  held instruction
- if_pc  output  PC_W  address of if_instr
- redirect_valid  input  1  branch/jump taken, flush fetch
- redirect_pc  input  PC_W  redirect target; low 2 bits ignored (treated as 0)
- pc_out  output  PC_W  current fetch PC

## Operation
- FSM states: IDLE, REQ, WAIT_RSP, DRAIN, HOLD.
- IDLE: entered on reset; all outputs inactive; next cycle -> REQ unconditionally (redirect in IDLE loads pc, still -> REQ).
- REQ: imem_req_valid=1, imem_addr=pc. req_ready=1 -> WAIT_RSP. Redirect with req_ready=0: pc<=redirect_pc, stay REQ (address may change while valid; memory samples only on ready). Redirect with req_ready=1: old request is in flight -> pc<=redirect_pc, -> DRAIN.
- WAIT_RSP: imem_req_valid=0. rsp_valid=1, no redirect: latch if_instr<=rsp_data, if_pc<=pc, pc<=pc+4, -> HOLD. Redirect (with or without rsp_valid): pc<=redirect_pc; if rsp_valid same cycle, response discarded, -> REQ; else -> DRAIN.
- DRAIN: waiting for a stale response. rsp_valid=1 -> discard, -> REQ. Redirect in DRAIN: pc<=redirect_pc, stay DRAIN (or -> REQ if rsp_valid same cycle).
- HOLD: if_valid=1, if_instr/if_pc stable. if_ready=1, no redirect -> REQ. Redirect: instruction killed regardless of if_ready, pc<=redirect_pc, -> REQ.
- Priority: rst > redirect_valid > handshakes.
- Only one outstanding memory request at any time; no response expected outside WAIT_RSP/DRAIN (rsp_valid there is ignored).
- PC arithmetic: pc+4 modulo 2^PC_W; 8'hFC wraps to 8'h00. pc low 2 bits always 0.

## Timing
- Reset (rst=1 at an edge): state=IDLE, pc_out=imem_addr=RESET_PC, imem_req_valid=0, if_valid=0, if_instr=0, if_pc=0. Reset mid-transaction drops everything; any later rsp_valid before the next accepted request is ignored.
- First request: imem_req_valid=1 in cycle 1 after rst deasserts (cycle 0 = IDLE).
- Response may arrive earliest 1 cycle after the accepting edge; unbounded wait allowed.
- Zero-wait memory (ready=1, rsp next cycle) with if_ready=1: one instruction per 3 cycles (REQ, WAIT_RSP, HOLD).
- if_valid rises the cycle after rsp_valid; falls the cycle after the if_ready handshake or redirect.
- Redirect takes effect at the edge it is sampled: pc_out shows redirect_pc next cycle; next request issued from redirect_pc no later than the cycle after any stale response.
- All outputs registered or decoded from state/registered pc only; no combinational path from inputs to outputs.

## Test plan
- Reset, RESET_PC=0, ready=1, rsp 1 cycle after accept, if_ready=1 -> if_pc sequence 0x00,0x04,0x08 with matching if_instr, if_valid every 3rd cycle.
- Backpressure: if_ready=0 for 5 cycles in HOLD -> if_valid/if_instr/if_pc stable, no imem_req_valid; if_ready=1 -> next request addr = if_pc+4.
- Redirect in WAIT_RSP to 0x40, response arrives 2 cycles later -> response discarded, next request addr 0x40, first if_pc = 0x40.
- Redirect same cycle as if_ready in HOLD (redirect_pc=0x23) -> instruction not consumed, next request addr 0x20.
- Wrap: redirect to 0xFC, two fetches -> if_pc 0xFC then 0x00.
- Reset asserted in WAIT_RSP, stale rsp_valid in cycle after reset -> ignored, first if_pc = RESET_PC.
